// File: rtl/neuron_pkg.sv
// Shared definitions for the forward and backward neuron blocks:
// FSM state encoding, datapath widths and the 8-bit saturating clamp.
package neuron_pkg;

    localparam int W    = 8;
    localparam int FRAC = 3;
    localparam int IW   = 2*W + 4;

    typedef enum logic [2:0] {IDLE, DELTA, GW1, GW2, GX1, GX2, DONE} state_e;

    function automatic logic signed [W-1:0] sat8(input logic signed [IW-1:0] v);
        if (v > 20'sd127) begin
            return 8'sh7F;
        end else if (v < -20'sd128) begin
            return 8'sh80;
        end else begin
            return v[W-1:0];
        end
    endfunction

endpackage

// File: rtl/nn_mul9.sv
// Combinational signed 9x9 multiplier shared by every step of the backward pass.
// Callers zero- or sign-extend their 8-bit operands to 9 bits before use.
module nn_mul9 (
    input  logic signed [8:0]  a_i,
    input  logic signed [8:0]  b_i,
    output logic signed [17:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/neuron_backprop_unit.sv
// Backward pass of the two-input leaky-ReLU neuron: delta, parameter updates
// and input errors, computed one product per cycle on a single multiplier.
module neuron_backprop_unit
    import neuron_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] x1_i,
    input  logic [W-1:0] x2_i,
    input  logic [W-1:0] w1_i,
    input  logic [W-1:0] w2_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] sum_i,
    input  logic [W-1:0] err_i,
    input  logic [2:0]   slope_i,
    input  logic [2:0]   lr_shift_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] w1_new_o,
    output logic [W-1:0] w2_new_o,
    output logic [W-1:0] b_new_o,
    output logic [W-1:0] dx1_o,
    output logic [W-1:0] dx2_o
);

    state_e state_q, state_d;

    logic        [W-1:0] x1_q, x2_q;
    logic signed [W-1:0] w1_q, w2_q, b_q, sum_q, err_q, delta_q;
    logic        [2:0]   slope_q, lr_q;
    logic signed [W-1:0] w1_new_q, w2_new_q, b_new_q, dx1_q, dx2_q;

    logic signed [W:0]     mul_a, mul_b;
    logic signed [2*W+1:0] prod;
    logic signed [W-1:0]   w_sel;
    logic signed [IW-1:0]  prod_ext, prod_sh, w_ext, b_ext, delta_ext, w_upd, b_upd;

    nn_mul9 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = DELTA;
            DELTA:   state_d = GW1;
            GW1:     state_d = GW2;
            GW2:     state_d = GX1;
            GX1:     state_d = GX2;
            GX2:     state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Delta is the common left operand except while delta itself is being formed.
    always_comb begin
        mul_a = {delta_q[W-1], delta_q};
        mul_b = {1'b0, x1_q};
        case (state_q)
            DELTA: begin
                mul_a = {err_q[W-1], err_q};
                mul_b = {{(W-2){1'b0}}, slope_q};
            end
            GW2:     mul_b = {1'b0, x2_q};
            GX1:     mul_b = {w1_q[W-1], w1_q};
            GX2:     mul_b = {w2_q[W-1], w2_q};
            default: ;
        endcase
    end

    // The leaky slope is a numerator over 8, which coincides with the FRAC scaling.
    assign prod_ext  = {{(IW-2*W-2){prod[2*W+1]}}, prod};
    assign prod_sh   = prod_ext >>> FRAC;
    assign w_sel     = (state_q == GW2) ? w2_q : w1_q;
    assign w_ext     = {{(IW-W){w_sel[W-1]}}, w_sel};
    assign b_ext     = {{(IW-W){b_q[W-1]}}, b_q};
    assign delta_ext = {{(IW-W){delta_q[W-1]}}, delta_q};
    assign w_upd     = w_ext - (prod_sh >>> lr_q);
    assign b_upd     = b_ext - (delta_ext >>> lr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            x1_q     <= '0;
            x2_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            err_q    <= '0;
            slope_q  <= '0;
            lr_q     <= '0;
            delta_q  <= '0;
            w1_new_q <= '0;
            w2_new_q <= '0;
            b_new_q  <= '0;
            dx1_q    <= '0;
            dx2_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (in_valid_i) begin
                    x1_q    <= x1_i;
                    x2_q    <= x2_i;
                    w1_q    <= w1_i;
                    w2_q    <= w2_i;
                    b_q     <= b_i;
                    sum_q   <= sum_i;
                    err_q   <= err_i;
                    slope_q <= slope_i;
                    lr_q    <= lr_shift_i;
                end
                DELTA: delta_q <= (sum_q > 8'sd0) ? err_q : prod_sh[W-1:0];
                GW1: begin
                    w1_new_q <= sat8(w_upd);
                    b_new_q  <= sat8(b_upd);
                end
                GW2:     w2_new_q <= sat8(w_upd);
                GX1:     dx1_q    <= sat8(prod_sh);
                GX2:     dx2_q    <= sat8(prod_sh);
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign w1_new_o    = w1_new_q;
    assign w2_new_o    = w2_new_q;
    assign b_new_o     = b_new_q;
    assign dx1_o       = dx1_q;
    assign dx2_o       = dx2_q;

endmodule

// File: tb/tb_neuron_backprop_unit.sv
// Self-checking bench for neuron_backprop_unit: directed cases with known
// answers plus random jobs checked against an integer-arithmetic model.
module tb_neuron_backprop_unit;

    typedef struct packed {
        logic [7:0] x1, x2, w1, w2, b, sum, err;
        logic [2:0] slope, lr;
    } job_t;

    typedef struct packed {
        logic [7:0] w1n, w2n, bn, dx1, dx2;
    } res_t;

    logic       clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] x1, x2, w1, w2, b, sum, err;
    logic [2:0] slope, lr_shift;
    logic [7:0] w1_new, w2_new, b_new, dx1, dx2;

    int vectors = 0;
    int miscompares = 0;

    neuron_backprop_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x1_i        (x1),
        .x2_i        (x2),
        .w1_i        (w1),
        .w2_i        (w2),
        .b_i         (b),
        .sum_i       (sum),
        .err_i       (err),
        .slope_i     (slope),
        .lr_shift_i  (lr_shift),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .w1_new_o    (w1_new),
        .w2_new_o    (w2_new),
        .b_new_o     (b_new),
        .dx1_o       (dx1),
        .dx2_o       (dx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: leaky-ReLU backward pass in plain integer arithmetic.
    function automatic logic [7:0] sat(input int v);
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return 8'(v);
    endfunction

    function automatic res_t model(input job_t j);
        res_t r;
        int s, e, wa, wb, bb, xa, xb, sl, lr, delta, g1, g2;
        s  = $signed(j.sum);
        e  = $signed(j.err);
        wa = $signed(j.w1);
        wb = $signed(j.w2);
        bb = $signed(j.b);
        xa = j.x1;
        xb = j.x2;
        sl = j.slope;
        lr = j.lr;
        if (s > 0) delta = e;
        else       delta = (e * sl) >>> 3;
        g1 = (delta * xa) >>> 3;
        g2 = (delta * xb) >>> 3;
        r.w1n = sat(wa - (g1 >>> lr));
        r.w2n = sat(wb - (g2 >>> lr));
        r.bn  = sat(bb - (delta >>> lr));
        r.dx1 = sat((delta * wa) >>> 3);
        r.dx2 = sat((delta * wb) >>> 3);
        return r;
    endfunction

    function automatic job_t case1(input logic [2:0] lr);
        job_t j;
        j = '{x1: 8'd16, x2: 8'd0, w1: 8'd8, w2: 8'd0, b: 8'd0,
              sum: 8'h10, err: 8'd8, slope: 3'd1, lr: lr};
        return j;
    endfunction

    function automatic job_t random_job();
        job_t j;
        j.x1    = 8'($urandom);
        j.x2    = 8'($urandom);
        j.w1    = 8'($urandom);
        j.w2    = 8'($urandom);
        j.b     = 8'($urandom);
        j.sum   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        j.err   = 8'($urandom);
        j.slope = 3'($urandom);
        j.lr    = 3'($urandom);
        return j;
    endfunction

    task automatic applyStimulus(input job_t j);
        x1 = j.x1; x2 = j.x2; w1 = j.w1; w2 = j.w2; b = j.b;
        sum = j.sum; err = j.err; slope = j.slope; lr_shift = j.lr;
    endtask

    // Offers one job, scrambles the inputs after acceptance and waits for results.
    task automatic run_job(input job_t j, output res_t obs, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        applyStimulus(j);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        applyStimulus(random_job());
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        obs = {w1_new, w2_new, b_new, dx1, dx2};
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10 ||
            {w1_new, w2_new, b_new, dx1, dx2} !== 40'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b out=%h expected rdy=1 vld=0 out=0",
                     in_ready, out_valid, {w1_new, w2_new, b_new, dx1, dx2});
        end
        rst = 1'b0;
    endtask

    task automatic test_positive();
        res_t obs;
        int lat;
        run_job(case1(3'd0), obs, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("[TB] FAIL pos_latency: got %0d expected 5", lat);
        end
        vectors++;
        if (obs !== 40'hF8_00_F8_08_00) begin
            miscompares++;
            $display("[TB] FAIL pos_result: got %h expected f800f80800", obs);
        end
        release_result();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL pos_transfer: got vld=%b rdy=%b expected vld=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_leaky();
        res_t obs;
        int lat;
        job_t j;
        j = '{x1: 8'd8, x2: 8'd0, w1: 8'd0, w2: 8'd0, b: 8'd0,
              sum: 8'h80, err: 8'd16, slope: 3'd2, lr: 3'd0};
        run_job(j, obs, lat);
        vectors++;
        if (obs !== 40'hFC_00_FC_00_00) begin
            miscompares++;
            $display("[TB] FAIL leaky_neg: got %h expected fc00fc0000", obs);
        end
        release_result();
        j = '{x1: 8'h99, x2: 8'd7, w1: 8'h35, w2: 8'hC2, b: 8'h11,
              sum: 8'h00, err: 8'h55, slope: 3'd0, lr: 3'd0};
        run_job(j, obs, lat);
        vectors++;
        if (obs !== 40'h35_C2_11_00_00) begin
            miscompares++;
            $display("[TB] FAIL leaky_zero: got %h expected 35c2110000", obs);
        end
        release_result();
    endtask

    task automatic test_saturation();
        res_t obs;
        int lat;
        job_t j;
        j = '{x1: 8'hFF, x2: 8'd0, w1: 8'h7F, w2: 8'd0, b: 8'd0,
              sum: 8'h01, err: 8'h80, slope: 3'd0, lr: 3'd0};
        run_job(j, obs, lat);
        vectors++;
        if (obs !== 40'h7F_00_7F_80_00) begin
            miscompares++;
            $display("[TB] FAIL saturation: got %h expected 7f007f8000", obs);
        end
        release_result();
    endtask

    task automatic test_learning_rate();
        res_t obs;
        int lat;
        run_job(case1(3'd3), obs, lat);
        vectors++;
        if (obs !== 40'h06_00_FF_08_00) begin
            miscompares++;
            $display("[TB] FAIL learning_rate: got %h expected 0600ff0800", obs);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        res_t obs, exp;
        int lat;
        exp = model(case1(3'd1));
        run_job(case1(3'd1), obs, lat);
        applyStimulus(random_job());
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready} !== 2'b10 ||
                {w1_new, w2_new, b_new, dx1, dx2} !== exp) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold: cycle %0d got vld=%b rdy=%b out=%h expected vld=1 rdy=0 out=%h",
                         i, out_valid, in_ready, {w1_new, w2_new, b_new, dx1, dx2}, exp);
            end
        end
        in_valid = 1'b0;
        release_result();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL backpressure_release: got vld=%b rdy=%b expected vld=0 rdy=1",
                     out_valid, in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL backpressure_no_second_job: got vld=%b rdy=%b expected vld=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midjob();
        res_t obs;
        int lat;
        applyStimulus(case1(3'd0));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01 ||
            {w1_new, w2_new, b_new, dx1, dx2} !== 40'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_midjob: got vld=%b rdy=%b out=%h expected vld=0 rdy=1 out=0",
                     out_valid, in_ready, {w1_new, w2_new, b_new, dx1, dx2});
        end
        run_job(case1(3'd0), obs, lat);
        vectors++;
        if (lat !== 5 || obs !== 40'hF8_00_F8_08_00) begin
            miscompares++;
            $display("[TB] FAIL after_reset_job: got lat=%0d out=%h expected lat=5 out=f800f80800",
                     lat, obs);
        end
        release_result();
    endtask

    task automatic test_random();
        res_t obs, exp;
        int lat;
        job_t j;
        for (int i = 0; i < 40; i++) begin
            j   = random_job();
            exp = model(j);
            run_job(j, obs, lat);
            vectors++;
            if (lat !== 5 || obs !== exp) begin
                miscompares++;
                $display("[TB] FAIL random_job %0d: job=%h got lat=%0d out=%h expected lat=5 out=%h",
                         i, j, lat, obs, exp);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        applyStimulus('0);
        test_reset();
        test_positive();
        test_leaky();
        test_saturation();
        test_learning_rate();
        test_backpressure();
        test_reset_midjob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neuron_backprop_unit.md
# neuron_backprop_unit

Backward-pass companion to the two-input forward neuron: given the output error of one neuron plus the operands captured during its forward pass, it computes the local delta through the leaky-ReLU derivative. From that delta it produces updated weights and bias and the errors propagated back to both inputs. A single shared signed multiplier is time-multiplexed under a small FSM with valid/ready handshakes on both sides, so a layer controller can stream backward jobs into it.

## Interface
- W, 8, datapath width of all operands/results
- FRAC, 3, fraction bits of fixed-point values (Q(W-FRAC).FRAC)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  unit accepts a job (high only in IDLE)
- x1, x2  in  W  forward inputs, unsigned Q5.3
- w1, w2, b  in  W  current weights/bias, signed Q4.3
- sum  in  W  forward pre-activation, signed
- err  in  W  output error dL/dy, signed Q4.3
- slope  in  3  leaky slope numerator, slope/8
- lr_shift  in  3  learning rate = 2^-lr_shift
- out_valid  out  1  results valid
- out_ready  in  1  consumer takes results
- w1_new, w2_new, b_new  out  W  updated parameters, signed
- dx1, dx2  out  W  back-propagated input errors, signed

## Operation
- Accept: in IDLE with in_valid=1, all inputs are captured into registers; inputs are don't-care afterwards.
- FSM states: IDLE -> DELTA -> GW1 -> GW2 -> GX1 -> GX2 -> DONE -> IDLE (DONE exits only when out_ready=1). No other transitions except reset.
- Multiplier: one signed (W+1)x(W+1) product per cycle; unsigned operands (x, slope) are zero-extended.
- DELTA: if sum > 0 (signed), delta = err; else delta = (err*slope)>>>3. sum = 0 takes the leaky branch. |delta| ≤ |err|, so no saturation is applied.
- GW1: g1 = (delta*x1)>>>FRAC; w1_new = sat(w1 - (g1>>>lr_shift)). b_new = sat(b - (delta>>>lr_shift)) in the same cycle, without using the multiplier.
- GW2: the same computation for w2/x2.
- GX1: dx1 = sat((delta*w1)>>>FRAC), using the captured old w1. GX2 does the same for dx2 with w2.
- Intermediates are at least 2W+2 bits wide. sat() clamps to [-128, 127]. All shifts are arithmetic.
- DONE: out_valid=1. Outputs are held stable until out_ready=1. in_valid is ignored outside IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, all data outputs 0, state IDLE.
- Accept on edge E. out_valid rises after edge E+5, i.e. a latency of 5 edges.
- Transfer on the first edge with out_valid & out_ready. out_valid drops after that edge. in_ready rises in the same cycle, since the state is IDLE.
- Minimum accept-to-accept interval is 7 cycles.
- Output registers update only on their producing state and hold otherwise.
- rst in any state, including mid-job: next edge forces the reset values, and the in-flight job is discarded with no partial outputs. rst has priority over both handshakes.

## Structure
- Package neuron_pkg holds the following, shared with the forward neuron:
  - state enum {IDLE, DELTA, GW1, GW2, GX1, GX2, DONE}
  - constants W=8, FRAC=3
  - sat8 function
- Sub-module nn_mul9: combinational signed 9x9 multiplier, instantiated once. The FSM owns operand muxing.

## Test plan
- Positive branch: sum=0x10, err=8, x1=16, x2=0, w1=8, w2=0, b=0, slope=1, lr_shift=0 -> w1_new=0xF8, w2_new=0, b_new=0xF8, dx1=8, dx2=0; out_valid 5 edges after accept.
- Leaky branch: sum=0x80, err=16, slope=2, x1=8, w1=0, b=0, lr_shift=0 -> delta=4, w1_new=0xFC, b_new=0xFC. Also sum=0, slope=0 -> outputs equal inputs (w, b) and dx=0.
- Saturation: sum=1, err=0x80, x1=255, w1=127, lr_shift=0 -> w1_new=127, dx1=0x80 (-128).
- Learning rate: case 1 with lr_shift=3 -> w1_new=6, b_new=0xFF.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> out_valid and outputs stable, in_ready=0, no second job accepted. Release -> one transfer, then in_ready=1.
- Reset mid-job: rst for one cycle in GW2 -> next edge out_valid=0, in_ready=1, outputs 0. An immediately following case-1 job yields the case-1 results.
